// File: rtl/register_file_write_bank.sv
// Write side of the 32-entry RISC-V integer register file.
// x1..x31 are flops, x0 is hard-wired zero, and sp/gp come out of reset at their ABI values.
module register_file_write_bank #(
  parameter int          n       = 32,
  parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
  input  logic         clk,
  input  logic         reset,
  // Write port: one write-back per rising edge when reg_write is high; there is no ready, the bank always accepts.
  input  logic         reg_write,
  input  logic [4:0]   write_register,
  input  logic [n-1:0] write_data,
  output logic [n-1:0] data_0,
  output logic [n-1:0] data_1,
  output logic [n-1:0] data_2,
  output logic [n-1:0] data_3,
  output logic [n-1:0] data_4,
  output logic [n-1:0] data_5,
  output logic [n-1:0] data_6,
  output logic [n-1:0] data_7,
  output logic [n-1:0] data_8,
  output logic [n-1:0] data_9,
  output logic [n-1:0] data_10,
  output logic [n-1:0] data_11,
  output logic [n-1:0] data_12,
  output logic [n-1:0] data_13,
  output logic [n-1:0] data_14,
  output logic [n-1:0] data_15,
  output logic [n-1:0] data_16,
  output logic [n-1:0] data_17,
  output logic [n-1:0] data_18,
  output logic [n-1:0] data_19,
  output logic [n-1:0] data_20,
  output logic [n-1:0] data_21,
  output logic [n-1:0] data_22,
  output logic [n-1:0] data_23,
  output logic [n-1:0] data_24,
  output logic [n-1:0] data_25,
  output logic [n-1:0] data_26,
  output logic [n-1:0] data_27,
  output logic [n-1:0] data_28,
  output logic [n-1:0] data_29,
  output logic [n-1:0] data_30,
  output logic [n-1:0] data_31,
  output logic         write_strobe,
  output logic [4:0]   last_written
);

  logic [n-1:0] regs [1:31];
  logic [31:1]  we;
  logic         accept;

  // One-hot decode; reg_write gates every enable so an unknown index with reg_write low writes nothing.
  always_comb begin
    we = '0;
    for (int k = 1; k < 32; k++) begin
      we[k] = reg_write && (write_register == 5'(k));
    end
  end

  assign accept = |we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < 32; k++) begin
        if (k == 2)      regs[k] <= n'(SP_INIT);
        else if (k == 3) regs[k] <= n'(GP_INIT);
        else             regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (we[k]) regs[k] <= write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_strobe <= 1'b0;
      last_written <= 5'd0;
    end else begin
      write_strobe <= accept;
      if (accept) last_written <= write_register;
    end
  end

  assign data_0  = '0;
  assign data_1  = regs[1];
  assign data_2  = regs[2];
  assign data_3  = regs[3];
  assign data_4  = regs[4];
  assign data_5  = regs[5];
  assign data_6  = regs[6];
  assign data_7  = regs[7];
  assign data_8  = regs[8];
  assign data_9  = regs[9];
  assign data_10 = regs[10];
  assign data_11 = regs[11];
  assign data_12 = regs[12];
  assign data_13 = regs[13];
  assign data_14 = regs[14];
  assign data_15 = regs[15];
  assign data_16 = regs[16];
  assign data_17 = regs[17];
  assign data_18 = regs[18];
  assign data_19 = regs[19];
  assign data_20 = regs[20];
  assign data_21 = regs[21];
  assign data_22 = regs[22];
  assign data_23 = regs[23];
  assign data_24 = regs[24];
  assign data_25 = regs[25];
  assign data_26 = regs[26];
  assign data_27 = regs[27];
  assign data_28 = regs[28];
  assign data_29 = regs[29];
  assign data_30 = regs[30];
  assign data_31 = regs[31];

endmodule

// File: tb/tb_register_file_write_bank.sv
// Directed bench for register_file_write_bank: an array model of x0..x31 checked every
// cycle, plus literal expectations for reset, x0 discard, back-to-back and async reset.
module tb_register_file_write_bank;

  localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT = 32'h1000_8000;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        reg_write = 1'b0;
  logic [4:0]  write_register = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] dut_data [32];
  logic        write_strobe;
  logic [4:0]  last_written;

  register_file_write_bank #(.n(32), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .write_register(write_register), .write_data(write_data),
    .data_0(dut_data[0]),   .data_1(dut_data[1]),   .data_2(dut_data[2]),   .data_3(dut_data[3]),
    .data_4(dut_data[4]),   .data_5(dut_data[5]),   .data_6(dut_data[6]),   .data_7(dut_data[7]),
    .data_8(dut_data[8]),   .data_9(dut_data[9]),   .data_10(dut_data[10]), .data_11(dut_data[11]),
    .data_12(dut_data[12]), .data_13(dut_data[13]), .data_14(dut_data[14]), .data_15(dut_data[15]),
    .data_16(dut_data[16]), .data_17(dut_data[17]), .data_18(dut_data[18]), .data_19(dut_data[19]),
    .data_20(dut_data[20]), .data_21(dut_data[21]), .data_22(dut_data[22]), .data_23(dut_data[23]),
    .data_24(dut_data[24]), .data_25(dut_data[25]), .data_26(dut_data[26]), .data_27(dut_data[27]),
    .data_28(dut_data[28]), .data_29(dut_data[29]), .data_30(dut_data[30]), .data_31(dut_data[31]),
    .write_strobe(write_strobe), .last_written(last_written)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic check_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register state plus the write-report outputs.
  logic [31:0] m_regs [32];
  logic        m_strobe;
  logic [4:0]  m_last;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_regs[2] = SP_INIT;
      m_regs[3] = GP_INIT;
      m_strobe = 1'b0;
      m_last = 5'd0;
    end else begin
      m_strobe = 1'b0;
      if (reg_write === 1'b1 && write_register != 5'd0) begin
        m_regs[write_register] = write_data;
        m_strobe = 1'b1;
        m_last = write_register;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 32; i++) check($sformatf("model_data_%0d", i), dut_data[i], m_regs[i]);
      check("model_write_strobe", 32'(write_strobe), 32'(m_strobe));
      check("model_last_written", 32'(last_written), 32'(m_last));
    end
  end

  // driver: present inputs on the falling edge, return 1 time unit after the next rising edge
  task automatic drive(input logic en, input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    reg_write = en;
    write_register = idx;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset for 2 cycles, then release
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_en = 1'b1;
    #1;
    check("rst_data_0", dut_data[0], 32'd0);
    check("rst_data_1", dut_data[1], 32'd0);
    check("rst_data_2", dut_data[2], 32'h7FFF_EFFC);
    check("rst_data_3", dut_data[3], 32'h1000_8000);
    for (int i = 4; i < 32; i++) check($sformatf("rst_data_%0d", i), dut_data[i], 32'd0);
    check("rst_write_strobe", 32'(write_strobe), 32'd0);
    check("rst_last_written", 32'(last_written), 32'd0);

    // 2: write x5
    drive(1'b1, 5'd5, 32'hDEAD_BEEF);
    check("wr5_data_5", dut_data[5], 32'hDEAD_BEEF);
    check("wr5_strobe", 32'(write_strobe), 32'd1);
    check("wr5_last", 32'(last_written), 32'd5);
    check("wr5_data_4", dut_data[4], 32'd0);

    // 3: write to x0 is discarded
    drive(1'b1, 5'd0, 32'hFFFF_FFFF);
    check("x0_data_0", dut_data[0], 32'd0);
    check("x0_strobe", 32'(write_strobe), 32'd0);
    check("x0_last", 32'(last_written), 32'd5);

    // 4: reg_write low, then unknown index with reg_write low
    drive(1'b0, 5'd7, 32'h1234_5678);
    check("nowr_data_7", dut_data[7], 32'd0);
    check("nowr_strobe", 32'(write_strobe), 32'd0);
    drive(1'b0, 5'bxxxxx, 32'hCAFE_F00D);
    check("xidx_data_5", dut_data[5], 32'hDEAD_BEEF);
    check("xidx_last", 32'(last_written), 32'd5);

    // 5: back-to-back writes to x31
    for (int v = 1; v <= 3; v++) begin
      exp_q.push_back(32'(v));
      drive(1'b1, 5'd31, 32'(v));
      check($sformatf("b2b_data_31_%0d", v), dut_data[31], exp_q.pop_front());
      check($sformatf("b2b_strobe_%0d", v), 32'(write_strobe), 32'd1);
      check($sformatf("b2b_last_%0d", v), 32'(last_written), 32'd31);
    end

    // gp is writable after reset
    drive(1'b1, 5'd3, 32'h0000_0055);
    check("gp_data_3", dut_data[3], 32'h0000_0055);
    drive(1'b0, 5'd0, 32'd0);
    check("idle_strobe", 32'(write_strobe), 32'd0);

    // 6: write sp, then async reset between edges with a write pending
    drive(1'b1, 5'd2, 32'hAAAA_5555);
    check("sp_data_2", dut_data[2], 32'hAAAA_5555);
    @(negedge clk);
    reg_write = 1'b1;
    write_register = 5'd4;
    write_data = 32'h4444_4444;
    #2;
    reset = 1'b0;
    #1;
    check("arst_data_2", dut_data[2], 32'h7FFF_EFFC);
    check("arst_data_3", dut_data[3], 32'h1000_8000);
    check("arst_data_31", dut_data[31], 32'd0);
    check("arst_strobe", 32'(write_strobe), 32'd0);
    check("arst_last", 32'(last_written), 32'd0);
    @(posedge clk);
    #1;
    check("arst_pending_data_4", dut_data[4], 32'd0);
    @(negedge clk);
    reg_write = 1'b0;
    reset = 1'b1;

    // after release, one more write and a few idle cycles
    drive(1'b1, 5'd17, 32'h0BAD_F00D);
    check("post_data_17", dut_data[17], 32'h0BAD_F00D);
    check("post_last", 32'(last_written), 32'd17);
    drive(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_write_bank.md
Name: register_file_write_bank

Overview:
- Write side of the 32-entry integer register file in the single-cycle RISC-V core.
- Accepts one write-back per clock from the write-back path.
- Decodes the 5-bit destination index and updates the selected register.
- Presents all 32 register values in parallel to the two read-port selector muxes.
- Enforces the x0-is-zero rule and the ABI reset values of sp and gp.

Parameters:
- n, 32: data width of every register.
- SP_INIT, 32'h7FFF_EFFC: reset value of x2 (sp).
- GP_INIT, 32'h1000_8000: reset value of x3 (gp).

Ports:
- clk  input  1  core clock; all register updates occur on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable from the control unit.
- write_register  input  5  destination register index (rd).
- write_data  input  n  write-back value.
- data_0 .. data_31  output  n each  current contents of x0..x31, driven directly from the storage flops.
- write_strobe  output  1  registered pulse, high for one cycle after an accepted write to x1..x31.
- last_written  output  5  index of the most recently written register.

Behaviour:
- Reset (reset low, asynchronous, no clock needed):
  - all data_k = 0, except data_2 = SP_INIT and data_3 = GP_INIT.
  - write_strobe = 0; last_written = 0.
  - Reset deassertion takes effect at the next rising clk edge.
- Storage: 31 n-bit flops for x1..x31. data_0 is a constant 0; x0 has no flop.
- Decode: a 5-to-32 one-hot decoder on write_register, gated by reg_write.
  - Only the selected register's enable is asserted.
  - All other registers hold their value.
- Write latency: with reg_write = 1 at a rising edge, data_[write_register] shows write_data immediately after that same edge. Reads in the same cycle see the old value; no internal bypass.
- Accepted write: reg_write = 1 and write_register != 0.
  - Next cycle: write_strobe = 1 and last_written = write_register.
  - Otherwise write_strobe returns to 0 and last_written holds.
- Write to x0 (write_register = 0, reg_write = 1):
  - Silently discarded; data_0 stays 0.
  - No write_strobe; last_written unchanged.
- reg_write = 0: no register changes, regardless of write_register and write_data.
- Back-to-back writes to the same register: each edge overwrites, so the last write wins. write_strobe stays high for consecutive accepted writes.
- Sp/gp: writable like any other register after reset. The INIT values apply only on reset.
- X handling: an X on write_register while reg_write = 0 must not corrupt any register.
- Reset asserted mid-write cycle: reset dominates. The values go straight to reset state and the pending write is lost.
- Width: write_data is stored unmodified; there is no sign or zero extension in this block.

Test Plan:
1. Assert reset low for 2 cycles, then release -> data_0=0, data_1=0, data_2=32'h7FFF_EFFC, data_3=32'h1000_8000, data_4..31=0, write_strobe=0, last_written=0.
2. reg_write=1, write_register=5, write_data=32'hDEAD_BEEF for one edge -> data_5=32'hDEAD_BEEF right after that edge; write_strobe=1 and last_written=5 next cycle; all other outputs unchanged.
3. reg_write=1, write_register=0, write_data=32'hFFFF_FFFF -> data_0 stays 0, write_strobe=0, last_written keeps its prior value.
4. reg_write=0, write_register=7, write_data=32'h1234_5678 -> data_7 unchanged.
5. Writes to x31 on consecutive edges with 32'h1, 32'h2, 32'h3 -> data_31=3 at the end; write_strobe high for 3 cycles.
6. Write 32'hAAAA_5555 to x2, then pull reset low between clock edges -> data_2 returns to SP_INIT immediately without a clock edge; write_strobe=0.
